ex6_step_scheduler: RTL and testbench

Shares one ex6 controller FSM instance between two requesters, one transaction at a time. Each transaction is either a single FSM step under a requester-supplied input vector or an FSM reset. The block arbitrates round-robin, drives the FSM inputs, gates FSM stepping, pulses the FSM reset, and returns the sampled FSM outputs to the granted requester. It sits between test/host requesters and the ex6 instance in the wrapper.

---
 rtl/ex6_step_scheduler_if.sv | 41 ++++
 rtl/ex6_step_scheduler.sv | 140 ++++++++++++++
 tb/tb_ex6_step_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex6_step_scheduler_if.sv
// Requester and FSM-side signal bundle for the ex6 step scheduler.
// The scheduler uses the slave modport; the environment uses master.
interface ex6_step_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             req0;
  logic             req1;
  logic             clr0;
  logic             clr1;
  logic [4:0]       vec0;
  logic [4:0]       vec1;
  logic             gnt0;
  logic             gnt1;
  logic [4:0]       x_out;
  logic             fsm_en;
  logic             fsm_rst;
  logic [7:0]       y_in;
  logic             rsp_valid;
  logic             rsp_id;
  logic [7:0]       rsp_data;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;

  modport slave (
    input  req0, req1, clr0, clr1,
    input  vec0, vec1, y_in,
    output gnt0, gnt1, x_out,
    output fsm_en, fsm_rst,
    output rsp_valid, rsp_id, rsp_data,
    output busy, step_cnt
  );

  modport master (
    output req0, req1, clr0, clr1,
    output vec0, vec1, y_in,
    input  gnt0, gnt1, x_out,
    input  fsm_en, fsm_rst,
    input  rsp_valid, rsp_id, rsp_data,
    input  busy, step_cnt
  );
endinterface

// File: rtl/ex6_step_scheduler.sv
// Round-robin sharing of one ex6 FSM between two requesters:
// single steps under a supplied input vector, or FSM resets.
module ex6_step_scheduler #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  ex6_step_scheduler_if.slave bus
);

  localparam int RCW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD =
    RCW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    STEP,
    FRST
  } state_e;

  state_e           state_q;
  logic [RCW-1:0]   rcnt_q;
  logic             last_gnt_q;
  logic             id_q;
  logic [4:0]       x_q;
  logic             en_q;
  logic             frst_q;
  logic             rv_q;
  logic             rid_q;
  logic [7:0]       rdata_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             pick0;
  logic             pick1;
  logic             gnt0_d;
  logic             gnt1_d;
  logic             clr_sel;
  logic [4:0]       vec_sel;

  // Grant is decided from the live requests in IDLE so the
  // transaction starts on the very next cycle.
  always_comb begin
    pick1   = bus.req1 & (~bus.req0 | ~last_gnt_q);
    pick0   = bus.req0 & ~pick1;
    gnt0_d  = (state_q == IDLE) & pick0;
    gnt1_d  = (state_q == IDLE) & pick1;
    clr_sel = pick1 ? bus.clr1 : bus.clr0;
    vec_sel = pick1 ? bus.vec1 : bus.vec0;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      rcnt_q     <= RST_LOAD;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      x_q        <= '0;
      en_q       <= 1'b0;
      frst_q     <= 1'b1;
      rv_q       <= 1'b0;
      rid_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (rcnt_q == '0) begin
            state_q <= IDLE;
            frst_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        IDLE: begin
          if (gnt0_d | gnt1_d) begin
            id_q       <= gnt1_d;
            last_gnt_q <= gnt1_d;
            busy_q     <= 1'b1;
            if (clr_sel) begin
              x_q     <= '0;
              frst_q  <= 1'b1;
              rcnt_q  <= RST_LOAD;
              state_q <= FRST;
            end else begin
              x_q     <= vec_sel;
              en_q    <= 1'b1;
              state_q <= STEP;
            end
          end
        end
        STEP: begin
          // y_in here is the post-step output under the held vector.
          en_q    <= 1'b0;
          rdata_q <= bus.y_in;
          cnt_q   <= cnt_d;
          rv_q    <= 1'b1;
          rid_q   <= id_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        FRST: begin
          if (rcnt_q == '0) begin
            frst_q  <= 1'b0;
            rv_q    <= 1'b1;
            rid_q   <= id_q;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_d;
  assign bus.gnt1      = gnt1_d;
  assign bus.x_out     = x_q;
  assign bus.fsm_en    = en_q;
  assign bus.fsm_rst   = frst_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.step_cnt  = cnt_q;

endmodule

// File: tb/tb_ex6_step_scheduler.sv
// Directed bench for ex6_step_scheduler: vector table of single
// transactions plus hand-written arbitration, reset and saturation runs.
module tb_ex6_step_scheduler;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cyc = '0;
  int          checks = 0;
  int          errors = 0;
  int          cnt_m = 0;
  logic        last_m = 1'b1;

  ex6_step_scheduler_if #(.CNT_W(16)) bus ();
  ex6_step_scheduler_if #(.CNT_W(4))  bs ();

  ex6_step_scheduler #(.RST_CYCLES(RC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ex6_step_scheduler #(.RST_CYCLES(RC), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .bus(bs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // y_in changes every cycle, so the sampling edge is observable.
  assign bus.y_in = {cyc[2:0], bus.x_out};
  assign bs.y_in  = 8'h5A;

  typedef struct {
    logic       r0;
    logic       c0;
    logic [4:0] v0;
    logic       r1;
    logic       c1;
    logic [4:0] v1;
    logic       id;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic c0,
                       input logic [4:0] v0, input logic r1,
                       input logic c1, input logic [4:0] v1);
    bus.req0 = r0; bus.clr0 = c0; bus.vec0 = v0;
    bus.req1 = r1; bus.clr1 = c1; bus.vec1 = v1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
    chk({tag, "_x_out"}, 32'(bus.x_out), 32'd0);
    chk({tag, "_fsm_en"}, 32'(bus.fsm_en), 32'd0);
    chk({tag, "_fsm_rst"}, 32'(bus.fsm_rst), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_step_cnt"}, 32'(bus.step_cnt), 32'd0);
  endtask

  // Release reset at a negedge; INIT must last two cycles.
  task automatic release_and_check_init(input string tag);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk({tag, "_busy"}, 32'(bus.busy), (i < 2) ? 32'd1 : 32'd0);
      chk({tag, "_fsm_rst"}, 32'(bus.fsm_rst),
          (i < 2) ? 32'd1 : 32'd0);
      chk({tag, "_en"}, 32'(bus.fsm_en), 32'd0);
      chk({tag, "_rv"}, 32'(bus.rsp_valid), 32'd0);
      if (i < 2) @(negedge clk);
    end
  endtask

  task automatic wait_gnt(output logic id, output logic [31:0] gcyc);
    int n = 0;
    #1;
    while (!(bus.gnt0 || bus.gnt1) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("gnt_seen", 32'(bus.gnt0 | bus.gnt1), 32'd1);
    chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    id   = bus.gnt1;
    gcyc = cyc;
  endtask

  // Called in the grant cycle; follows the transaction to its response.
  task automatic finish_txn(input logic clr, input logic id,
                            input logic [4:0] vec,
                            input logic [31:0] gcyc);
    int lat;
    int nr;
    logic [31:0] t1;
    logic [7:0]  ed;
    t1 = gcyc + 1;
    ed = clr ? 8'h00 : {t1[2:0], vec};
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("t1_fsm_en", 32'(bus.fsm_en), 32'(!clr));
    chk("t1_x_out", 32'(bus.x_out), 32'(clr ? 5'd0 : vec));
    chk("t1_fsm_rst", 32'(bus.fsm_rst), 32'(clr));
    chk("t1_busy", 32'(bus.busy), 32'd1);
    lat = 1;
    nr  = bus.fsm_rst ? 1 : 0;
    while (!bus.rsp_valid && lat < 12) begin
      @(negedge clk); #1; lat++;
      if (bus.fsm_rst) nr++;
    end
    if (!clr) cnt_m++;
    last_m = id;
    chk("rsp_latency", 32'(lat), clr ? 32'(RC + 1) : 32'd2);
    chk("fsm_rst_cycles", 32'(nr), clr ? 32'(RC) : 32'd0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
    chk("step_cnt", 32'(bus.step_cnt), 32'(cnt_m));
    chk("rsp_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic        gid;
    logic        eid;
    logic        first;
    logic [31:0] gc;
    logic [31:0] gcs [6];
    logic [31:0] tt;
    logic [4:0]  ev;
    int          n;

    tv[0] = '{1'b1, 1'b0, 5'b00011, 1'b0, 1'b0, 5'b00000, 1'b0};
    tv[1] = '{1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 5'b10100, 1'b1};
    tv[2] = '{1'b1, 1'b0, 5'b01010, 1'b1, 1'b0, 5'b00101, 1'b0};
    tv[3] = '{1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 5'b10001, 1'b1};
    tv[4] = '{1'b1, 1'b1, 5'b11011, 1'b0, 1'b0, 5'b00000, 1'b0};
    tv[5] = '{1'b1, 1'b0, 5'b01001, 1'b1, 1'b1, 5'b11110, 1'b1};
    tv[6] = '{1'b1, 1'b0, 5'b01100, 1'b0, 1'b1, 5'b00111, 1'b0};

    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    bs.req0 = 1'b0; bs.clr0 = 1'b0; bs.vec0 = 5'd0;
    bs.req1 = 1'b0; bs.clr1 = 1'b0; bs.vec1 = 5'd0;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    release_and_check_init("init");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_en", 32'(bus.fsm_en), 32'd0);
      chk("idle_rv", 32'(bus.rsp_valid), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      drive(tv[i].r0, tv[i].c0, tv[i].v0,
            tv[i].r1, tv[i].c1, tv[i].v1);
      wait_gnt(gid, gc);
      chk($sformatf("tv%0d_gnt_id", i), 32'(gid), 32'(tv[i].id));
      finish_txn(tv[i].id ? tv[i].c1 : tv[i].c0, tv[i].id,
                 tv[i].id ? tv[i].v1 : tv[i].v0, gc);
    end

    // Reset request from 1 against a step from 0, last grant was 0.
    drive(1'b1, 1'b0, 5'b00110, 1'b1, 1'b1, 5'b00000);
    #1;
    chk("cc_gnt1", 32'(bus.gnt1), 32'd1);
    chk("cc_gnt0", 32'(bus.gnt0), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'b00110, 1'b0, 1'b0, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("cc_fsm_rst", 32'(bus.fsm_rst), 32'd1);
      chk("cc_en", 32'(bus.fsm_en), 32'd0);
      chk("cc_no_gnt0", 32'(bus.gnt0), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("cc_rst_drop", 32'(bus.fsm_rst), 32'd0);
    chk("cc_rv", 32'(bus.rsp_valid), 32'd1);
    chk("cc_rid", 32'(bus.rsp_id), 32'd1);
    chk("cc_rdata", 32'(bus.rsp_data), 32'd0);
    chk("cc_cnt", 32'(bus.step_cnt), 32'(cnt_m));
    chk("cc_gnt0_same_cycle", 32'(bus.gnt0), 32'd1);
    gc = cyc;
    finish_txn(1'b0, 1'b0, 5'b00110, gc);

    // Both requesters stepping continuously: strict alternation.
    first = ~last_m;
    drive(1'b1, 1'b0, 5'b00111, 1'b1, 1'b0, 5'b11000);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k % 2 == 0) begin
        eid = first ^ 1'((k / 2) % 2);
        chk("rr_gnt0", 32'(bus.gnt0), 32'(!eid));
        chk("rr_gnt1", 32'(bus.gnt1), 32'(eid));
        if (k > 0) begin
          chk("rr_rv", 32'(bus.rsp_valid), 32'd1);
          chk("rr_rid", 32'(bus.rsp_id), 32'(!eid));
        end
        gcs[k / 2] = cyc;
      end else begin
        chk("rr_gap", 32'(bus.gnt0 | bus.gnt1), 32'd0);
        chk("rr_en", 32'(bus.fsm_en), 32'd1);
      end
      if (k == 11) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
    end
    #1;
    eid = first ^ 1'b1;
    tt  = gcs[5] + 1;
    ev  = eid ? 5'b11000 : 5'b00111;
    cnt_m += 6;
    last_m = eid;
    chk("rr_last_rv", 32'(bus.rsp_valid), 32'd1);
    chk("rr_last_rid", 32'(bus.rsp_id), 32'(eid));
    chk("rr_last_data", 32'(bus.rsp_data), 32'({tt[2:0], ev}));
    chk("rr_cnt", 32'(bus.step_cnt), 32'(cnt_m));

    // Reset asserted while a step is in flight.
    @(negedge clk);
    drive(1'b1, 1'b0, 5'b10101, 1'b0, 1'b0, 5'd0);
    wait_gnt(gid, gc);
    chk("ab_gnt_id", 32'(gid), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("ab_step_en", 32'(bus.fsm_en), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_vals("ab");
    cnt_m  = 0;
    last_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("ab_hold_rv", 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    release_and_check_init("reinit");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("ab_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 17; i++) begin
      bs.req0 = 1'b1;
      bs.vec0 = 5'(i);
      #1;
      n = 0;
      while (!bs.gnt0 && n < 8) begin
        @(negedge clk); #1; n++;
      end
      chk("sat_gnt", 32'(bs.gnt0), 32'd1);
      @(negedge clk);
      bs.req0 = 1'b0;
      @(negedge clk); #1;
      chk("sat_rv", 32'(bs.rsp_valid), 32'd1);
      chk("sat_data", 32'(bs.rsp_data), 32'h5A);
      chk($sformatf("sat_cnt%0d", i), 32'(bs.step_cnt),
          (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
